matvec_pe_array: RTL and testbench

- Parametrised successor to the single-processor matrix-vector datapath behind the UART front end.
- Buffers an N x N matrix (row-major, push_A side) and an N-element vector (push_B side), then computes y = A*b with NUM_PE parallel multiply-accumulate units working on row groups.
- Results are serialised into an output FIFO that the UART transmit side pops one word at a time.

---
 rtl/matvec_pe_array.sv | 237 +++++++++++++++++++++++
 tb/tb_matvec_pe_array.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/matvec_pe_array.sv
// Matrix-vector engine: buffers an N x N matrix and an N-vector, computes y = A*b with NUM_PE
// parallel MACs over row groups, and queues results in a FIFO for the transmit side.
module matvec_pe_array #(
  parameter int unsigned DW     = 8,
  parameter int unsigned MAX_N  = 8,
  parameter int unsigned NUM_PE = 4,
  parameter int unsigned ACC_W  = 2 * DW + $clog2(MAX_N)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [$clog2(MAX_N+1)-1:0] n_size,
  input  logic                       start,
  input  logic                       push_A,
  input  logic [DW-1:0]              data_A,
  input  logic                       push_B,
  input  logic [DW-1:0]              data_B,
  input  logic                       pop_res,
  output logic                       full_A,
  output logic                       full_B,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic                       empty_res,
  output logic [ACC_W-1:0]           res_data
);

  localparam int unsigned NW  = $clog2(MAX_N + 1);
  localparam int unsigned AD  = MAX_N * MAX_N;
  localparam int unsigned MAW = (AD > 1) ? $clog2(AD) : 1;
  localparam int unsigned CAW = $clog2(AD + 1);
  localparam int unsigned IW  = (MAX_N > 1) ? $clog2(MAX_N) : 1;
  localparam int unsigned PW  = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam int unsigned AXW = 2 * NW + 2;

  typedef enum logic [1:0] {StIdle, StMac, StDrain} state_e;

  state_e            state_q, state_d;
  logic [NW-1:0]     n_q, n_d;
  logic [NW-1:0]     base_q, base_d;
  logic [IW-1:0]     col_q, col_d;
  logic [PW-1:0]     pe_q, pe_d;
  logic [CAW-1:0]    cnt_a_q, cnt_a_d;
  logic [NW-1:0]     cnt_b_q, cnt_b_d;
  logic [ACC_W-1:0]  acc_q [NUM_PE];
  logic [ACC_W-1:0]  acc_d [NUM_PE];
  logic              err_q, err_d;
  logic              done_q, done_d;

  logic [DW-1:0]     mat_q [AD];
  logic [DW-1:0]     vec_q [MAX_N];
  logic [ACC_W-1:0]  fifo_q [MAX_N];
  logic [IW-1:0]     wr_q, rd_q;
  logic [NW-1:0]     fifo_cnt_q;

  logic              wr_a, wr_b, flush, res_push, do_pop;
  logic [2*NW-1:0]   nn_live;
  logic              a_room, b_room, n_ok, start_ok;
  logic [NW-1:0]     rows_left;
  logic              drain_last, more_rows;

  // Fullness tracks the live n_size so the loader sees it change immediately.
  assign nn_live  = (2*NW)'(n_size) * (2*NW)'(n_size);
  assign full_A   = ((2*NW)'(cnt_a_q) == nn_live);
  assign full_B   = (cnt_b_q == n_size);
  assign a_room   = ((2*NW)'(cnt_a_q) < nn_live) && (cnt_a_q < CAW'(AD));
  assign b_room   = (cnt_b_q < n_size) && (cnt_b_q < NW'(MAX_N));
  assign n_ok     = (n_size != '0) && (n_size <= NW'(MAX_N));
  assign start_ok = n_ok && full_A && full_B;

  assign rows_left  = n_q - base_q;
  assign drain_last = (pe_q == PW'(NUM_PE - 1)) ||
                      ((NW+1)'(pe_q) + (NW+1)'(1) == (NW+1)'(rows_left));
  assign more_rows  = ((NW+1)'(base_q) + (NW+1)'(NUM_PE)) < (NW+1)'(n_q);

  always_comb begin
    logic [NW:0]     row;
    logic [AXW-1:0]  addr;
    logic [2*DW-1:0] prod;
    row      = '0;
    addr     = '0;
    prod     = '0;
    state_d  = state_q;
    n_d      = n_q;
    base_d   = base_q;
    col_d    = col_q;
    pe_d     = pe_q;
    cnt_a_d  = cnt_a_q;
    cnt_b_d  = cnt_b_q;
    acc_d    = acc_q;
    err_d    = 1'b0;
    done_d   = 1'b0;
    wr_a     = 1'b0;
    wr_b     = 1'b0;
    flush    = 1'b0;
    res_push = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (push_A) begin
          if (a_room) begin
            wr_a    = 1'b1;
            cnt_a_d = cnt_a_q + CAW'(1);
          end else begin
            err_d = 1'b1;
          end
        end
        if (push_B) begin
          if (b_room) begin
            wr_b    = 1'b1;
            cnt_b_d = cnt_b_q + NW'(1);
          end else begin
            err_d = 1'b1;
          end
        end
        if (start) begin
          if (start_ok) begin
            state_d = StMac;
            n_d     = n_size;
            base_d  = '0;
            col_d   = '0;
            pe_d    = '0;
            acc_d   = '{default: '0};
            flush   = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      StMac: begin
        err_d = push_A || push_B;
        for (int p = 0; p < int'(NUM_PE); p++) begin
          row = (NW+1)'(base_q) + (NW+1)'(p);
          if (row < (NW+1)'(n_q)) begin
            addr     = AXW'(row) * AXW'(n_q) + AXW'(col_q);
            prod     = (2*DW)'(mat_q[MAW'(addr)]) * (2*DW)'(vec_q[col_q]);
            acc_d[p] = acc_q[p] + ACC_W'(prod);
          end
        end
        if (col_q == IW'(n_q - NW'(1))) begin
          state_d = StDrain;
          pe_d    = '0;
        end else begin
          col_d = col_q + IW'(1);
        end
      end

      StDrain: begin
        err_d    = push_A || push_B;
        res_push = 1'b1;
        if (drain_last) begin
          if (more_rows) begin
            state_d = StMac;
            base_d  = base_q + NW'(NUM_PE);
            col_d   = '0;
            acc_d   = '{default: '0};
          end else begin
            state_d = StIdle;
            done_d  = 1'b1;
            cnt_a_d = '0;
            cnt_b_d = '0;
          end
        end else begin
          pe_d = pe_q + PW'(1);
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      n_q     <= '0;
      base_q  <= '0;
      col_q   <= '0;
      pe_q    <= '0;
      cnt_a_q <= '0;
      cnt_b_q <= '0;
      acc_q   <= '{default: '0};
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      base_q  <= base_d;
      col_q   <= col_d;
      pe_q    <= pe_d;
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
      acc_q   <= acc_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  // Element storage carries no reset; validity is tracked by the counters.
  always_ff @(posedge clk) begin
    if (wr_a) mat_q[MAW'(cnt_a_q)] <= data_A;
    if (wr_b) vec_q[IW'(cnt_b_q)] <= data_B;
    if (res_push) fifo_q[wr_q] <= acc_q[pe_q];
  end

  function automatic logic [IW-1:0] ptr_inc(input logic [IW-1:0] p);
    return (p == IW'(MAX_N - 1)) ? '0 : p + IW'(1);
  endfunction

  assign do_pop = pop_res && (fifo_cnt_q != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q       <= '0;
      rd_q       <= '0;
      fifo_cnt_q <= '0;
    end else if (flush) begin
      wr_q       <= '0;
      rd_q       <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (res_push) wr_q <= ptr_inc(wr_q);
      if (do_pop) rd_q <= ptr_inc(rd_q);
      if (res_push && !do_pop) begin
        fifo_cnt_q <= fifo_cnt_q + NW'(1);
      end else if (!res_push && do_pop) begin
        fifo_cnt_q <= fifo_cnt_q - NW'(1);
      end
    end
  end

  assign empty_res = (fifo_cnt_q == '0);
  assign res_data  = empty_res ? '0 : fifo_q[rd_q];
  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_matvec_pe_array.sv
// Bench for matvec_pe_array: directed jobs with hand-computed results; a scoreboard queue holds
// expected results and a monitor pops the FIFO and compares whenever data is present.
module tb_matvec_pe_array;

  logic        clk;
  logic        rst;
  logic [3:0]  n_size;
  logic        start;
  logic        push_A;
  logic [7:0]  data_A;
  logic        push_B;
  logic [7:0]  data_B;
  logic        pop_res;
  logic        full_A;
  logic        full_B;
  logic        busy;
  logic        done;
  logic        err;
  logic        empty_res;
  logic [18:0] res_data;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [18:0] exp_q[$];
  logic        pop_always = 1'b0;
  logic [7:0]  a_vals [64];
  logic [7:0]  b_vals [8];

  matvec_pe_array dut (
    .clk       (clk),
    .rst       (rst),
    .n_size    (n_size),
    .start     (start),
    .push_A    (push_A),
    .data_A    (data_A),
    .push_B    (push_B),
    .data_B    (data_B),
    .pop_res   (pop_res),
    .full_A    (full_A),
    .full_B    (full_B),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .empty_res (empty_res),
    .res_data  (res_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Monitor/consumer: compares the FIFO head on every cycle it will be popped.
  initial begin
    pop_res = 1'b0;
    forever begin
      @(negedge clk);
      if (rst && !empty_res) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", res_data, 0);
        end else begin
          check("result", res_data, exp_q.pop_front());
        end
      end
      pop_res = pop_always || !empty_res;
    end
  end

  task automatic do_reset();
    rst    = 1'b0;
    start  = 1'b0;
    push_A = 1'b0;
    push_B = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic load(input int n, input int na, input int nb);
    n_size = 4'(n);
    for (int i = 0; i < na; i++) begin
      push_A = 1'b1;
      data_A = a_vals[i];
      @(negedge clk);
    end
    push_A = 1'b0;
    for (int i = 0; i < nb; i++) begin
      push_B = 1'b1;
      data_B = b_vals[i];
      @(negedge clk);
    end
    push_B = 1'b0;
  endtask

  task automatic run_job(input int lat);
    int cycles;
    check("busy_before_start", busy, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_accept", busy, 1);
    check("err_on_accept", err, 0);
    cycles = 0;
    while (!done && cycles < 200) begin
      @(negedge clk);
      cycles++;
    end
    check("done_latency", cycles, lat);
    check("busy_at_done", busy, 0);
    check("full_A_cleared", full_A, 0);
  endtask

  task automatic wait_drain();
    int cycles;
    cycles = 0;
    while (exp_q.size() != 0 && cycles < 50) begin
      @(negedge clk);
      cycles++;
    end
    check("results_outstanding", exp_q.size(), 0);
  endtask

  initial begin
    rst    = 1'b0;
    n_size = 4'd5;
    start  = 1'b0;
    push_A = 1'b0;
    data_A = '0;
    push_B = 1'b0;
    data_B = '0;
    #3;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_empty", empty_res, 1);
    check("rst_res_data", res_data, 0);
    check("rst_full_A", full_A, 0);
    check("rst_full_B", full_B, 0);
    do_reset();

    // N=5, A[i][j]=i+j+1, b[j]=j+1
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++) a_vals[i*5+j] = 8'(i + j + 1);
    for (int j = 0; j < 5; j++) b_vals[j] = 8'(j + 1);
    load(5, 25, 5);
    check("n5_full_A", full_A, 1);
    check("n5_full_B", full_B, 1);
    exp_q.push_back(19'd55);
    exp_q.push_back(19'd70);
    exp_q.push_back(19'd85);
    exp_q.push_back(19'd100);
    exp_q.push_back(19'd115);
    run_job(15);
    wait_drain();

    // N=8, all 255: largest accumulation
    for (int i = 0; i < 64; i++) a_vals[i] = 8'd255;
    for (int j = 0; j < 8; j++) b_vals[j] = 8'd255;
    load(8, 64, 8);
    for (int i = 0; i < 8; i++) exp_q.push_back(19'd520200);
    run_job(24);
    wait_drain();

    // N=3 with an incomplete vector: start rejected
    do_reset();
    load(3, 9, 2);
    check("n3_full_A", full_A, 1);
    check("n3_full_B", full_B, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("n3_start_err", err, 1);
    check("n3_busy", busy, 0);
    @(negedge clk);
    check("n3_err_pulse_end", err, 0);
    check("n3_busy_later", busy, 0);
    check("n3_no_results", empty_res, 1);

    // N=2: overfill the matrix, then a normal job
    do_reset();
    a_vals[0] = 8'd1;
    a_vals[1] = 8'd2;
    a_vals[2] = 8'd3;
    a_vals[3] = 8'd4;
    a_vals[4] = 8'd99;
    b_vals[0] = 8'd5;
    b_vals[1] = 8'd6;
    load(2, 4, 0);
    check("n2_full_A", full_A, 1);
    check("n2_err_clean", err, 0);
    push_A = 1'b1;
    data_A = 8'd99;
    @(negedge clk);
    push_A = 1'b0;
    check("n2_overfill_err", err, 1);
    check("n2_full_A_kept", full_A, 1);
    @(negedge clk);
    check("n2_err_pulse_end", err, 0);
    load(2, 0, 2);
    check("n2_full_B", full_B, 1);
    exp_q.push_back(19'd17);
    exp_q.push_back(19'd39);
    run_job(4);
    wait_drain();

    // Reset during MAC of an N=6 job, then N=1
    for (int i = 0; i < 36; i++) a_vals[i] = 8'd3;
    for (int j = 0; j < 6; j++) b_vals[j] = 8'd2;
    load(6, 36, 6);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_busy_before_rst", busy, 1);
    rst = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_err", err, 0);
    check("mid_rst_empty", empty_res, 1);
    check("mid_rst_res_data", res_data, 0);
    check("mid_rst_full_B", full_B, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    a_vals[0] = 8'd7;
    b_vals[0] = 8'd9;
    load(1, 1, 1);
    exp_q.push_back(19'd63);
    run_job(2);
    wait_drain();

    // N=5 with pop_res held high throughout
    pop_always = 1'b1;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++) a_vals[i*5+j] = 8'(i + j + 1);
    for (int j = 0; j < 5; j++) b_vals[j] = 8'(j + 1);
    load(5, 25, 5);
    check("pa_err_after_load", err, 0);
    exp_q.push_back(19'd55);
    exp_q.push_back(19'd70);
    exp_q.push_back(19'd85);
    exp_q.push_back(19'd100);
    exp_q.push_back(19'd115);
    run_job(15);
    wait_drain();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("pa_empty_idle", empty_res, 1);
      check("pa_no_err_empty_pop", err, 0);
    end
    pop_always = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
